// File: rtl/alu_uart_sequencer.sv
// Sequencer between the UART and the ALU.
// Collects A, B and opcode, then sends the result.
module alu_uart_sequencer #(
  parameter int NB_DATA        = 8,
  parameter int N_BITS_OP      = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_tx_done,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic [NB_DATA-1:0]   o_alu_a,
  output logic [NB_DATA-1:0]   o_alu_b,
  output logic [N_BITS_OP-1:0] o_alu_op,
  output logic                 o_tx_start,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  // Count value on the edge where the counter steps to TIMEOUT_CYCLES-1
  localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    START,
    WAIT_LO,
    WAIT_HI
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          expire;

  // Inter-byte gap has used up its budget
  assign expire = (cnt == CNT_FIRE);

  // Frame sequencing, timeout and all registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= GET_A;
      cnt        <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      unique case (state)
        GET_A: begin
          cnt <= '0;
          if (i_rx_done) begin
            o_alu_a <= i_rx_data;
            o_busy  <= 1'b1;
            state   <= GET_B;
          end
        end
        GET_B: begin
          if (i_rx_done) begin
            o_alu_b <= i_rx_data;
            cnt     <= '0;
            state   <= GET_OP;
          end else begin
            cnt <= cnt + 1'b1;
            if (expire) begin
              o_timeout <= 1'b1;
              o_busy    <= 1'b0;
              state     <= GET_A;
            end
          end
        end
        GET_OP: begin
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[N_BITS_OP-1:0];
            cnt      <= '0;
            state    <= EXEC;
          end else begin
            cnt <= cnt + 1'b1;
            if (expire) begin
              o_timeout <= 1'b1;
              o_busy    <= 1'b0;
              state     <= GET_A;
            end
          end
        end
        EXEC: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= START;
        end
        START: begin
          state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!i_tx_done) begin
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= GET_A;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer.
// Directed plus random frames against a frame-level model.
module tb_alu_uart_sequencer;

  localparam int T = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int passed = 0;

  alu_uart_sequencer #(
    .NB_DATA(8),
    .N_BITS_OP(6),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_rx_done(rx_done),
    .i_rx_data(rx_data),
    .i_tx_done(tx_done),
    .i_alu_result(alu_result),
    .o_alu_a(alu_a),
    .o_alu_b(alu_b),
    .o_alu_op(alu_op),
    .o_tx_start(tx_start),
    .o_tx_data(tx_data),
    .o_busy(busy),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [5:0] op
  );
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  // ALU stub seen by the DUT
  always_comb alu_result = alu_ref(alu_a, alu_b, alu_op);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // Next byte lands g cycles after the previous one
  task automatic wait_gap(input int g, input string tag);
    for (int i = 1; i < g; i++) begin
      chk(tag, timeout, 0);
      tick();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, alu_a, 0);
    chk({tag, "_b"}, alu_b, 0);
    chk({tag, "_op"}, alu_op, 0);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_to"}, timeout, 0);
  endtask

  task automatic run_frame(input logic [7:0] a,
                           input logic [7:0] b,
                           input logic [7:0] opb,
                           input int g1,
                           input int g2,
                           input logic [7:0] exp,
                           input bit inject,
                           input bit rst_mid);
    int k;
    int lo;
    send(a);
    chk("cap_a", alu_a, a);
    chk("busy_a", busy, 1);
    wait_gap(g1, "no_to_b");
    send(b);
    chk("cap_b", alu_b, b);
    chk("hold_a", alu_a, a);
    wait_gap(g2, "no_to_op");
    send(opb);
    chk("cap_op", alu_op, opb[5:0]);
    chk("start_early", tx_start, 0);
    tick();
    chk("start", tx_start, 1);
    chk("tx_data", tx_data, exp);
    tick();
    chk("start_once", tx_start, 0);
    if (rst_mid) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_zero("rst_mid");
      tx_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (i == 3) tx_done = 1'b1;
        tick();
        chk("rst_no_start", tx_start, 0);
        chk("rst_idle", busy, 0);
      end
      return;
    end
    k = $urandom_range(0, 2);
    repeat (k) begin
      tick();
      chk("txd_hold", tx_data, exp);
    end
    tx_done = 1'b0;
    lo = inject ? 3 : $urandom_range(1, 4);
    for (int i = 0; i < lo; i++) begin
      chk("busy_tx", busy, 1);
      if (inject && i == 1) begin
        rx_data = 8'h55;
        rx_done = 1'b1;
      end else begin
        rx_done = 1'b0;
      end
      tick();
    end
    rx_done = 1'b0;
    tx_done = 1'b1;
    chk("busy_hi", busy, 1);
    tick();
    chk("busy_done", busy, 0);
    chk("no_restart", tx_start, 0);
    chk("end_a", alu_a, a);
    chk("end_b", alu_b, b);
    chk("end_op", alu_op, opb[5:0]);
    chk("end_txd", tx_data, exp);
  endtask

  initial begin
    logic [7:0] ops [5];
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] ro;
    ops[0] = 8'h20;
    ops[1] = 8'h22;
    ops[2] = 8'h24;
    ops[3] = 8'h25;
    ops[4] = 8'h26;

    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b1;

    // 1: reset with stray bytes
    for (int i = 0; i < 10; i++) begin
      rx_data = 8'(8'hA0 + i);
      rx_done = i[0];
      tick();
    end
    rx_done = 1'b0;
    chk_zero("reset");
    reset = 1'b0;
    tick();
    chk_zero("post_reset");

    // 2: ADD
    run_frame(8'h64, 8'h0A, 8'h20, 1, 3, 8'h6E, 0, 0);

    // 3: SUB with opcode upper bits set
    run_frame(8'h64, 8'h05, 8'hE2, 2, 1, 8'h5F, 0, 0);

    // 4: partial frame times out
    send(8'h11);
    chk("to_cap_a", alu_a, 8'h11);
    for (int i = 1; i < T; i++) begin
      chk("to_wait", timeout, 0);
      chk("to_busy", busy, 1);
      tick();
    end
    chk("to_pulse", timeout, 1);
    chk("to_idle", busy, 0);
    chk("to_keep_a", alu_a, 8'h11);
    chk("to_keep_b", alu_b, 8'h05);
    chk("to_keep_op", alu_op, 6'h22);
    tick();
    chk("to_once", timeout, 0);
    // bytes on the last allowed cycle still count
    run_frame(8'h01, 8'h02, 8'h20, T - 1, T - 1, 8'h03, 0, 0);

    // 5: stray byte while transmitting
    run_frame(8'h33, 8'h44, 8'h25, 1, 1, 8'h77, 1, 0);
    run_frame(8'h0F, 8'h00, 8'h20, 2, 2, 8'h0F, 0, 0);

    // random frames
    for (int n = 0; n < 12; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = ops[$urandom_range(0, 4)] | {2'($urandom), 6'h00};
      run_frame(ra, rb, ro,
                $urandom_range(1, 6), $urandom_range(1, 6),
                alu_ref(ra, rb, ro[5:0]), 0, 0);
    end

    // 6: reset while waiting for the transmitter
    run_frame(8'h12, 8'h34, 8'h20, 1, 1, 8'h46, 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
